// File: rtl/sm53b_arb_pkg.sv
// sm53b_arb_pkg: shared constants and the in-flight tag type for the
// shared mantissa-multiplier scheduler.
package sm53b_arb_pkg;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_ASIZE   = 53;
    localparam int unsigned DEF_BSIZE   = 53;
    localparam int unsigned DEF_MUL_LAT = 2;
    localparam int unsigned PSIZE       = DEF_ASIZE + DEF_BSIZE;

    // Tag id is sized for the largest supported NREQ (8); narrower
    // configurations use the low bits only.
    localparam int unsigned TAG_IDW = 3;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/sm53b_arb_rr.sv
// sm53b_arb_rr: round-robin picker. Grants the first request at or after
// the pointer (upward, with wrap); on advance the pointer moves to one past
// the granted requester.
module sm53b_arb_rr
    import sm53b_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Priority search starting at r_ptr, wrapping modulo NREQ
    always_comb begin
        logic [PW-1:0] v_j;
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        v_j     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            v_j = PW'((32'(r_ptr) + k) % NREQ);
            if (!w_found && i_req[v_j]) begin
                o_grant[v_j] = 1'b1;
                w_idx        = v_j;
                w_found      = 1'b1;
            end
        end
    end

    // Pointer moves past the winner only when a transfer actually happens
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= PW'((32'(w_idx) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/sm53b_arb.sv
// sm53b_arb: shares one external MUL_LAT-stage pipelined multiplier among
// NREQ requesters. A tag pipeline tracks which requester owns each
// multiplier stage; products return through one registered result port
// with backpressure. Optional statistics: define SM53B_ARB_STAT_EN to add
// issue_cnt / stall_cnt.
module sm53b_arb
    import sm53b_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned ASIZE   = DEF_ASIZE,
    parameter int unsigned BSIZE   = DEF_BSIZE,
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned IDW     = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ASIZE-1:0]  req_a,
    input  logic [NREQ*BSIZE-1:0]  req_b,
    output logic                   mul_ce,
    output logic [ASIZE-1:0]       mul_a,
    output logic [BSIZE-1:0]       mul_b,
    input  logic [ASIZE+BSIZE-1:0] mul_p,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [IDW-1:0]         res_id,
    output logic [ASIZE+BSIZE-1:0] res_p,
    output logic                   busy
`ifdef SM53B_ARB_STAT_EN
    ,
    output logic [NREQ*16-1:0]     issue_cnt,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int unsigned PW = ASIZE + BSIZE;

    logic [NREQ-1:0]    w_grant;
    logic               w_stall;
    logic               w_take;
    logic               w_xfer;
    logic [TAG_IDW-1:0] w_gid;

    tag_t               r_tag [MUL_LAT];
    logic               r_res_valid;
    logic [IDW-1:0]     r_res_id;
    logic [PW-1:0]      r_res_p;

    // Only a held result stalls; reset forces the multiplier to keep draining
    assign w_stall   = r_res_valid & ~res_ready;
    assign mul_ce    = rst | ~w_stall;
    assign w_take    = mul_ce & ~rst;
    assign req_ready = w_grant & {NREQ{w_take}};
    assign w_xfer    = |(req_valid & req_ready);

    sm53b_arb_rr #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req_valid),
        .i_advance (w_xfer),
        .o_grant   (w_grant)
    );

    // Steer the accepted requester's operands (zero when idle) and encode its id
    always_comb begin
        w_gid = '0;
        mul_a = '0;
        mul_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (req_valid[k] & req_ready[k]) begin
                w_gid = TAG_IDW'(k);
                mul_a = req_a[k*ASIZE +: ASIZE];
                mul_b = req_b[k*BSIZE +: BSIZE];
            end
        end
    end

    // Tag pipeline moves in lock-step with the multiplier's ce-qualified stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else if (mul_ce) begin
            r_tag[0] <= '{valid: w_xfer, id: w_gid};
            for (int unsigned k = 1; k < MUL_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Result register: swaps in the next product whenever the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_p     <= '0;
        end else if (mul_ce) begin
            r_res_valid <= r_tag[MUL_LAT-1].valid;
            r_res_id    <= r_tag[MUL_LAT-1].id[IDW-1:0];
            r_res_p     <= mul_p;
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_p     = r_res_p;

    // Busy while any tag is in flight or a result is held
    always_comb begin
        busy = r_res_valid;
        for (int unsigned k = 0; k < MUL_LAT; k++) begin
            busy = busy | r_tag[k].valid;
        end
    end

`ifdef SM53B_ARB_STAT_EN
    logic [15:0] r_issue [NREQ];
    logic [15:0] r_stall_cnt;

    // Saturating per-requester issue counters and stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                r_issue[k] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k] && (r_issue[k] != '1)) begin
                    r_issue[k] <= r_issue[k] + 16'd1;
                end
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Flatten the counter array onto the output bus
    always_comb begin
        issue_cnt = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            issue_cnt[k*16 +: 16] = r_issue[k];
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/sm53b_arb.md
# sm53b_arb

Round-robin scheduler that shares one pipelined 53x53 unsigned mantissa multiplier (MREG+PREG, 2 ce-qualified stages) between NREQ floating-point requesters in the FMA datapath. It accepts operand pairs over valid/ready handshakes and issues at most one per cycle. A tag pipeline runs in lock-step with the multiplier. Each product is returned with its requester ID through a single registered result port with backpressure.

## Interface
- NREQ, 4, number of requesters (2..8)
- ASIZE, 53, operand A width
- BSIZE, 53, operand B width
- MUL_LAT, 2, ce-qualified register stages inside the multiplier (1..5)
- IDW, $clog2(NREQ), requester ID width (derived)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*ASIZE  operand A; slice i belongs to requester i
- req_b  in  NREQ*BSIZE  operand B; slice i belongs to requester i
- mul_ce  out  1  multiplier clock enable
- mul_a  out  ASIZE  multiplier operand A
- mul_b  out  BSIZE  multiplier operand B
- mul_p  in  ASIZE+BSIZE  multiplier product
- res_valid  out  1  result register holds a product
- res_ready  in  1  consumer accepts the result
- res_id  out  IDW  requester that owns res_p
- res_p  out  ASIZE+BSIZE  product
- busy  out  1  any tag in flight, or res_valid

## Operation
- The pipeline stalls only when the output is held: stall = res_valid & ~res_ready. mul_ce = ~stall.
- mul_ce is 1 while rst is high, so the multiplier drains.
- Grant is round-robin: the first req_valid[i] at or after ptr, searching upward with wrap.
- req_ready[i] = grant[i] & mul_ce & ~rst, combinational. A transfer occurs when req_valid[i] & req_ready[i].
- On a transfer:
  - mul_a/mul_b carry requester i's slices.
  - Tag stage 0 loads {1, i}.
  - ptr becomes (i+1) mod NREQ.
- With no transfer, mul_a/mul_b = 0 and tag stage 0 loads valid 0. ptr is unchanged.
- Tag pipeline: vld[0..MUL_LAT-1] and id[0..MUL_LAT-1]. It shifts only when mul_ce=1. Tag stage k describes multiplier stage k.
- Result register:
  - When mul_ce=1 it loads res_valid = vld[MUL_LAT-1], res_id = id[MUL_LAT-1], res_p = mul_p.
  - When stalled it holds all three.
  - When res_valid=0, res_p and res_id are don't-care.
- Products always leave in issue order. Results are never dropped or duplicated.
- Arithmetic is unsigned, full width ASIZE+BSIZE, with no rounding here.
- A requester must hold its req_a/req_b stable while req_valid=1 and ready=0. The block does not register requests.

## Timing
- Reset values: res_valid 0, res_id 0, res_p 0, all vld 0, ptr 0, busy 0, req_ready 0, mul_a/mul_b 0.
- Unstalled latency is MUL_LAT+1 cycles (3 by default): a transfer at edge t gives res_valid=1 after edge t+MUL_LAT+1.
- Throughput is one issue per cycle. Back-to-back grants to the same requester are allowed only when it is the sole requester.
- Each stall cycle adds exactly one cycle of latency to every tag in flight.
- While stalled, no grant is made and ptr is frozen.
- If rst is asserted mid-operation, all tags in flight and the held result are discarded the next cycle. No result appears for them.
- Simultaneous res_ready and a new arriving product: the register swaps in the same edge with no bubble.

## Configuration
- SM53B_ARB_STAT_EN defined:
  - Adds output issue_cnt, NREQ*16 bits: per-requester 16-bit counters, incremented on each transfer, saturating at 0xFFFF, cleared by rst.
  - Adds output stall_cnt, 16 bits: counts cycles with stall=1, saturating, cleared by rst.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Package sm53b_arb_pkg holds:
  - the default MUL_LAT, ASIZE and BSIZE constants;
  - PSIZE = ASIZE+BSIZE;
  - the tag struct typedef {valid, id}.
- Sub-module sm53b_arb_rr holds the round-robin picker and ptr register. Inputs are the request vector and advance; the output is the one-hot grant.
- The multiplier stays outside this block and is instantiated by the parent.

## Test plan
- Single request, requester 2: a=3, b=5, res_ready=1 → res_valid after 3 cycles with res_id=2 and res_p=15. busy then drops one cycle later.
- All four valid continuously with unique operands → grants 0,1,2,3,0,…; results return in that order, one per cycle.
- Hold res_ready=0 for 4 cycles while 3 ops are in flight → mul_ce=0 and req_ready=0 during the hold. Release → 3 results follow consecutively, with correct id and p.
- Only requester 3 is valid, then requesters 0 and 3 both assert with ptr=0 → grant 0 first, then 3. Wrap-around is correct.
- Assert rst for 1 cycle with 2 ops in flight and res_valid=1 → res_valid=0 next cycle, no stale result later, ptr=0.
- With SM53B_ARB_STAT_EN: 70000 grants to requester 1 → issue_cnt[1] saturates at 0xFFFF and the other counters stay correct.
